prco_mem_ctrl: RTL and testbench
================================

// Module: prco_mem_ctrl
// PURPOSE
//  Initiator side of the prco_lmem port. Sequences instruction fetches and ALU load/stores onto the
//  single-ported local memory: drives the fetch/alu enables, address and write data, then waits for
//  the memory's q_ce_dec/q_ce_reg completion strobe and returns the read data to the requester.
//  Sits between the core pipeline (fetch stage, ALU/LS stage) and prco_lmem. One transaction in flight.
// PARAMETERS
//  P_TIMEOUT   15   max WAIT cycles before a transaction is aborted with q_err (4-bit counter)
// PORTS
//  i_clk         in   1   core clock; all logic on posedge
//  i_reset       in   1   synchronous, active-high reset
//  i_fetch_req   in   1   fetch request; level, held until q_fetch_ack
//  i_fetch_addr  in   16  fetch address (PC)
//  q_fetch_ack   out  1   1-cycle pulse: q_instr valid
//  q_instr       out  16  fetched instruction word
//  i_ls_req      in   1   load/store request; level, held until q_ls_ack
//  i_ls_we       in   1   1=store, 0=load
//  i_ls_addr     in   16  data address
//  i_ls_wdata    in   16  store data
//  q_ls_ack      out  1   1-cycle pulse: load data valid / store committed
//  q_ls_rdata    out  16  load data
//  q_err         out  1   sticky timeout flag, cleared only by reset
//  q_ce_fetch    out  1   to lmem i_ce_fetch
//  q_ce_alu      out  1   to lmem i_ce_alu
//  q_mem_we      out  1   to lmem i_mem_we
//  q_mem_addr    out  16  to lmem i_mem_addr
//  q_mem_dina    out  16  to lmem i_mem_dina
//  i_mem_douta   in   16  from lmem q_mem_douta
//  i_ce_dec      in   1   from lmem q_ce_dec (fetch done)
//  i_ce_reg      in   1   from lmem q_ce_reg (alu access done)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output and the timeout counter = 0.
//  - FSM IDLE -> WAIT -> DONE -> IDLE. IDLE: if i_ls_req, latch ls (q_ce_alu=1, q_mem_we=i_ls_we,
//    addr/dina from ls ports); else if i_fetch_req, latch fetch (q_ce_fetch=1, q_mem_we=0, addr=PC).
//    LS has priority; the fetch stays pending and is issued after the LS reaches IDLE again.
//  - q_ce_fetch/q_ce_alu/q_mem_we are high for exactly one cycle (first WAIT cycle) then forced 0.
//    q_mem_addr/q_mem_dina hold their value until the next issue.
//  - WAIT: on the strobe matching the issued type (i_ce_dec for fetch, i_ce_reg for ls) capture
//    i_mem_douta into q_instr (fetch) or q_ls_rdata (load only; stores leave q_ls_rdata unchanged),
//    pulse the matching ack, go to DONE. Mismatched strobe is ignored.
//  - Latency: req sampled at edge N -> enable high after N -> lmem data/strobe after N+1 -> ack high
//    after N+2 (ack visible 3 cycles after request cycle). Back-to-back: one transaction per 4 cycles.
//  - DONE: one dead cycle (ack already dropped) so a requester that drops req in the ack cycle is not
//    re-issued. Next request is sampled in IDLE.
//  - Timeout: 4-bit counter increments each WAIT cycle without strobe; at P_TIMEOUT set q_err, pulse
//    the pending ack with undefined data and go to DONE (requester never hangs).
//  - Requester dropping req mid-transaction: transaction completes normally, ack still pulses.
//  - Reset mid-transaction: abort immediately, no ack, enables low on the following cycle.
// STRUCTURE
//  - FSM state encodings (`MEMC_IDLE/`MEMC_WAIT/`MEMC_DONE) and `REG_WIDTH come from
//    inc/prco_constants.v; no local width literals.
//  - One sub-module: prco_wdog_ctr (load/clear/increment, terminal-count output) for the timeout.
// TESTING (bench instantiates prco_mem_ctrl + prco_lmem)
//  - Fetch 0x0000 -> q_fetch_ack after 3 cycles, q_instr=16'h20ab; fetch 0x0001 -> 16'h21cd.
//  - Store 0x1234 @0x0010, then load 0x0010 -> q_ls_rdata=16'h1234; store ack leaves rdata unchanged.
//  - i_fetch_req and i_ls_req (load 0x00aa) same cycle -> ls ack first (rdata=16'h00CA), fetch ack
//    exactly 4 cycles later; q_ce_fetch and q_ce_alu never high together.
//  - Hold req high for 12 cycles -> exactly 3 issues, acks spaced 4 cycles, no double issue.
//  - Tie i_ce_dec/i_ce_reg low (no lmem) -> ack + q_err after P_TIMEOUT WAIT cycles; q_err stays 1
//    until i_reset.
//  - Assert i_reset during WAIT -> no ack, all outputs 0 next cycle, next fetch completes normally.

Source files
------------

// File: rtl/prco_mem_ctrl_pkg.sv
// Shared types and constants for the prco local-memory initiator.
// Holds the FSM encodings, register width and watchdog geometry used by the controller.
package prco_mem_ctrl_pkg;

  localparam int REG_WIDTH = 16;
  localparam int WDOG_W    = 4;

  typedef enum logic [1:0] {
    MEMC_IDLE = 2'd0,
    MEMC_WAIT = 2'd1,
    MEMC_DONE = 2'd2
  } memc_state_t;

endpackage

// File: rtl/prco_wdog_ctr.sv
// Transaction watchdog: clearable, incrementing counter with a terminal-count flag.
// The flag rises one count early so the caller times out on the P_TIMEOUT-th idle cycle.
module prco_wdog_ctr #(
  parameter int P_TIMEOUT = 15,
  parameter int CNT_W     = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic q_tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      count <= '0;
    end else if (i_inc) begin
      count <= count + 1'b1;
    end
  end

  assign q_tc = (count == CNT_W'(P_TIMEOUT - 1));

endmodule

// File: rtl/prco_mem_ctrl.sv
// Initiator for the prco_lmem port: arbitrates fetch vs load/store (LS wins), issues one
// access at a time, waits for the matching completion strobe and returns the data with an ack.
module prco_mem_ctrl
  import prco_mem_ctrl_pkg::*;
#(
  parameter int P_TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_fetch_req,
  input  logic [REG_WIDTH-1:0] i_fetch_addr,
  output logic                 q_fetch_ack,
  output logic [REG_WIDTH-1:0] q_instr,
  input  logic                 i_ls_req,
  input  logic                 i_ls_we,
  input  logic [REG_WIDTH-1:0] i_ls_addr,
  input  logic [REG_WIDTH-1:0] i_ls_wdata,
  output logic                 q_ls_ack,
  output logic [REG_WIDTH-1:0] q_ls_rdata,
  output logic                 q_err,
  output logic                 q_ce_fetch,
  output logic                 q_ce_alu,
  output logic                 q_mem_we,
  output logic [REG_WIDTH-1:0] q_mem_addr,
  output logic [REG_WIDTH-1:0] q_mem_dina,
  input  logic [REG_WIDTH-1:0] i_mem_douta,
  input  logic                 i_ce_dec,
  input  logic                 i_ce_reg
);

  memc_state_t          state, state_nxt;
  logic                 txn_ls, txn_ls_nxt;
  logic                 txn_we, txn_we_nxt;
  logic                 fetch_ack_nxt, ls_ack_nxt, err_nxt;
  logic                 ce_fetch_nxt, ce_alu_nxt, mem_we_nxt;
  logic [REG_WIDTH-1:0] instr_nxt, ls_rdata_nxt, mem_addr_nxt, mem_dina_nxt;
  logic                 wd_clr, wd_inc, wd_tc, strobe;

  prco_wdog_ctr #(
    .P_TIMEOUT (P_TIMEOUT),
    .CNT_W     (WDOG_W)
  ) u_wdog (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (wd_clr),
    .i_inc   (wd_inc),
    .q_tc    (wd_tc)
  );

  // Completion strobe must match the kind of access that was issued.
  assign strobe = txn_ls ? i_ce_reg : i_ce_dec;

  always_comb begin
    state_nxt     = state;
    txn_ls_nxt    = txn_ls;
    txn_we_nxt    = txn_we;
    fetch_ack_nxt = 1'b0;
    ls_ack_nxt    = 1'b0;
    err_nxt       = q_err;
    ce_fetch_nxt  = 1'b0;
    ce_alu_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    instr_nxt     = q_instr;
    ls_rdata_nxt  = q_ls_rdata;
    mem_addr_nxt  = q_mem_addr;
    mem_dina_nxt  = q_mem_dina;
    wd_clr        = 1'b0;
    wd_inc        = 1'b0;
    unique case (state)
      MEMC_IDLE: begin
        if (i_ls_req) begin
          state_nxt    = MEMC_WAIT;
          txn_ls_nxt   = 1'b1;
          txn_we_nxt   = i_ls_we;
          ce_alu_nxt   = 1'b1;
          mem_we_nxt   = i_ls_we;
          mem_addr_nxt = i_ls_addr;
          mem_dina_nxt = i_ls_wdata;
          wd_clr       = 1'b1;
        end else if (i_fetch_req) begin
          state_nxt    = MEMC_WAIT;
          txn_ls_nxt   = 1'b0;
          txn_we_nxt   = 1'b0;
          ce_fetch_nxt = 1'b1;
          mem_addr_nxt = i_fetch_addr;
          wd_clr       = 1'b1;
        end
      end
      MEMC_WAIT: begin
        if (strobe) begin
          state_nxt = MEMC_DONE;
          if (txn_ls) begin
            ls_ack_nxt = 1'b1;
            if (!txn_we) ls_rdata_nxt = i_mem_douta;
          end else begin
            fetch_ack_nxt = 1'b1;
            instr_nxt     = i_mem_douta;
          end
        end else if (wd_tc) begin
          // Abort so the requester never hangs; data is left as-is.
          state_nxt     = MEMC_DONE;
          err_nxt       = 1'b1;
          ls_ack_nxt    = txn_ls;
          fetch_ack_nxt = !txn_ls;
        end else begin
          wd_inc = 1'b1;
        end
      end
      MEMC_DONE: state_nxt = MEMC_IDLE;
      default:   state_nxt = MEMC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= MEMC_IDLE;
      txn_ls      <= 1'b0;
      txn_we      <= 1'b0;
      q_fetch_ack <= 1'b0;
      q_ls_ack    <= 1'b0;
      q_err       <= 1'b0;
      q_ce_fetch  <= 1'b0;
      q_ce_alu    <= 1'b0;
      q_mem_we    <= 1'b0;
      q_instr     <= '0;
      q_ls_rdata  <= '0;
      q_mem_addr  <= '0;
      q_mem_dina  <= '0;
    end else begin
      state       <= state_nxt;
      txn_ls      <= txn_ls_nxt;
      txn_we      <= txn_we_nxt;
      q_fetch_ack <= fetch_ack_nxt;
      q_ls_ack    <= ls_ack_nxt;
      q_err       <= err_nxt;
      q_ce_fetch  <= ce_fetch_nxt;
      q_ce_alu    <= ce_alu_nxt;
      q_mem_we    <= mem_we_nxt;
      q_instr     <= instr_nxt;
      q_ls_rdata  <= ls_rdata_nxt;
      q_mem_addr  <= mem_addr_nxt;
      q_mem_dina  <= mem_dina_nxt;
    end
  end

endmodule

// File: tb/tb_prco_mem_ctrl.sv
// Bench for prco_mem_ctrl with a small behavioural local-memory model answering one cycle
// after each enable; vector table for single transactions plus hand-written corner sequences.
module tb_prco_mem_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        fetch_req, ls_req, ls_we;
  logic [15:0] fetch_addr, ls_addr, ls_wdata;
  logic        fetch_ack, ls_ack, err;
  logic [15:0] instr, ls_rdata;
  logic        ce_fetch, ce_alu, mem_we;
  logic [15:0] mem_addr, mem_dina;
  logic [15:0] mem_douta;
  logic        ce_dec, ce_reg;
  logic        lmem_en;
  logic [15:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prco_mem_ctrl #(.P_TIMEOUT(15)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_fetch_req  (fetch_req),
    .i_fetch_addr (fetch_addr),
    .q_fetch_ack  (fetch_ack),
    .q_instr      (instr),
    .i_ls_req     (ls_req),
    .i_ls_we      (ls_we),
    .i_ls_addr    (ls_addr),
    .i_ls_wdata   (ls_wdata),
    .q_ls_ack     (ls_ack),
    .q_ls_rdata   (ls_rdata),
    .q_err        (err),
    .q_ce_fetch   (ce_fetch),
    .q_ce_alu     (ce_alu),
    .q_mem_we     (mem_we),
    .q_mem_addr   (mem_addr),
    .q_mem_dina   (mem_dina),
    .i_mem_douta  (mem_douta),
    .i_ce_dec     (ce_dec),
    .i_ce_reg     (ce_reg)
  );

  // Memory model: contents preloaded on reset, strobe one cycle after the enable.
  always @(posedge clk) begin
    ce_dec <= 1'b0;
    ce_reg <= 1'b0;
    if (i_reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[0]     <= 16'h20ab;
      mem[1]     <= 16'h21cd;
      mem[2]     <= 16'h22ef;
      mem[8'haa] <= 16'h00ca;
      mem_douta  <= 16'h0000;
    end else if (lmem_en) begin
      if (ce_fetch) begin
        mem_douta <= mem[mem_addr[7:0]];
        ce_dec    <= 1'b1;
      end
      if (ce_alu) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_dina;
        else        mem_douta <= mem[mem_addr[7:0]];
        ce_reg <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and hold it until its ack (or the cycle bound).
  task automatic run_txn(input bit is_ls, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, output int lat, output logic [15:0] data);
    lat  = -1;
    data = 16'hxxxx;
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      fetch_req = 1'b1; fetch_addr = addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (is_ls ? ls_ack : fetch_ack) begin
        lat  = c;
        data = is_ls ? ls_rdata : instr;
        break;
      end
    end
    fetch_req = 1'b0;
    ls_req    = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          is_ls;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          lat;
    logic [15:0] data;
    int          ls_c, f_c, overlap, issues, nack;
    int          ack_c [3];

    vecs[0] = '{"fetch0",    1'b0, 1'b0, 16'h0000, 16'h0000, 16'h20ab, 3};
    vecs[1] = '{"fetch1",    1'b0, 1'b0, 16'h0001, 16'h0000, 16'h21cd, 3};
    vecs[2] = '{"store10",   1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0000, 3};
    vecs[3] = '{"load10",    1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 3};
    vecs[4] = '{"store11",   1'b1, 1'b1, 16'h0011, 16'hbeef, 16'h1234, 3};
    vecs[5] = '{"load11",    1'b1, 1'b0, 16'h0011, 16'h0000, 16'hbeef, 3};
    vecs[6] = '{"loadaa",    1'b1, 1'b0, 16'h00aa, 16'h0000, 16'h00ca, 3};
    vecs[7] = '{"fetch2",    1'b0, 1'b0, 16'h0002, 16'h0000, 16'h22ef, 3};

    i_reset = 1'b1; fetch_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    fetch_addr = '0; ls_addr = '0; ls_wdata = '0; lmem_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {10'd0, fetch_ack, ls_ack, err, ce_fetch, ce_alu, mem_we}, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_rdata", ls_rdata, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    i_reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].is_ls, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, data);
      check({vecs[i].name, "_lat"}, 16'(lat), 16'(vecs[i].exp_lat));
      check({vecs[i].name, "_data"}, data, vecs[i].exp_data);
    end

    // Fetch and load requested in the same cycle: LS first, fetch 4 cycles later.
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 16'h0001;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h00aa;
    ls_c = -1; f_c = -1; overlap = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ce_fetch && ce_alu) overlap++;
      if (ls_ack) begin
        ls_c = c; ls_req = 1'b0;
        check("arb_ldata", ls_rdata, 16'h00ca);
      end
      if (fetch_ack) begin
        f_c = c; fetch_req = 1'b0;
        check("arb_instr", instr, 16'h21cd);
      end
    end
    check("arb_ls_lat", 16'(ls_c), 16'd3);
    check("arb_fetch_lat", 16'(f_c), 16'd7);
    check("arb_overlap", 16'(overlap), 16'd0);

    // Request held for 12 cycles: three issues with acks every 4 cycles.
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 16'h0000;
    issues = 0; nack = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ce_fetch) issues++;
      if (fetch_ack) begin
        if (nack < 3) ack_c[nack] = c;
        nack++;
      end
    end
    fetch_req = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ce_fetch) issues++;
      if (fetch_ack) nack++;
    end
    check("hold_issues", 16'(issues), 16'd3);
    check("hold_acks", 16'(nack), 16'd3);
    if (nack == 3) begin
      check("hold_sp0", 16'(ack_c[1] - ack_c[0]), 16'd4);
      check("hold_sp1", 16'(ack_c[2] - ack_c[1]), 16'd4);
    end

    // No memory response: watchdog abort with sticky error.
    lmem_en = 1'b0;
    run_txn(1'b0, 1'b0, 16'h0000, 16'h0000, lat, data);
    check("to_lat", 16'(lat), 16'd16);
    check("to_err", {15'd0, err}, 16'd1);
    lmem_en = 1'b1;
    repeat (5) @(posedge clk);
    run_txn(1'b0, 1'b0, 16'h0001, 16'h0000, lat, data);
    check("to_after_data", data, 16'h21cd);
    check("to_sticky", {15'd0, err}, 16'd1);
    do_reset();
    check("to_cleared", {15'd0, err}, 16'd0);

    // Reset asserted while a fetch is in WAIT.
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 16'h0001;
    @(posedge clk); #1;
    check("rw_issued", {15'd0, ce_fetch}, 16'd1);
    i_reset = 1'b1; fetch_req = 1'b0;
    @(posedge clk); #1;
    check("rw_outs", {10'd0, fetch_ack, ls_ack, err, ce_fetch, ce_alu, mem_we}, 16'h0000);
    check("rw_addr", mem_addr, 16'h0000);
    i_reset = 1'b0;
    nack = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (fetch_ack || ls_ack) nack++;
    end
    check("rw_no_ack", 16'(nack), 16'd0);
    run_txn(1'b0, 1'b0, 16'h0000, 16'h0000, lat, data);
    check("rw_next_lat", 16'(lat), 16'd3);
    check("rw_next_data", data, 16'h20ab);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
